// File: rtl/id_ex_register_pkg.sv
// Shared decode/execute definitions: widths, control
// encodings and the pipeline bundle types.
package id_ex_register_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [1:0] RES_IMM  = 2'b11;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_JAL  = 2'b01;
   localparam logic [1:0] JMP_JALR = 2'b10;

   localparam logic [1:0] BR_NONE  = 2'b00;
   localparam logic [1:0] BR_BEQ   = 2'b01;
   localparam logic [1:0] BR_BNE   = 2'b10;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b101;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       lui;
      logic [1:0] result_src;
      logic [1:0] jump;
      logic [1:0] branch;
      logic [2:0] alu_control;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] imm_ext;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
   } data_t;

   typedef struct packed {
      ctrl_t ctrl;
      data_t data;
   } id_ex_t;

   // All-zero bundle: an ADD that is never written back.
   localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: hazard controls, D-side
// inputs and registered E-side outputs.
interface id_ex_register_if;
   import id_ex_register_pkg::*;

   logic            StallE;
   logic            FlushE;
   logic            ValidD;
   logic            RegWriteD;
   logic            MemWriteD;
   logic            ALUSrcD;
   logic            LUID;
   logic [1:0]      ResultSrcD;
   logic [1:0]      JumpD;
   logic [1:0]      BranchD;
   logic [2:0]      ALUControlD;
   logic [XLEN-1:0] RD1D;
   logic [XLEN-1:0] RD2D;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic [XLEN-1:0] ImmExtD;
   logic [REGW-1:0] Rs1D;
   logic [REGW-1:0] Rs2D;
   logic [REGW-1:0] RdD;

   logic            ValidE;
   logic            RegWriteE;
   logic            MemWriteE;
   logic            ALUSrcE;
   logic            LUIE;
   logic [1:0]      ResultSrcE;
   logic [1:0]      JumpE;
   logic [1:0]      BranchE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic [XLEN-1:0] ImmExtE;
   logic [REGW-1:0] Rs1E;
   logic [REGW-1:0] Rs2E;
   logic [REGW-1:0] RdE;

   modport master (
      output StallE, FlushE, ValidD,
      output RegWriteD, MemWriteD, ALUSrcD, LUID,
      output ResultSrcD, JumpD, BranchD, ALUControlD,
      output RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
      output Rs1D, Rs2D, RdD,
      input  ValidE, RegWriteE, MemWriteE, ALUSrcE, LUIE,
      input  ResultSrcE, JumpE, BranchE, ALUControlE,
      input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
      input  Rs1E, Rs2E, RdE
   );

   modport slave (
      input  StallE, FlushE, ValidD,
      input  RegWriteD, MemWriteD, ALUSrcD, LUID,
      input  ResultSrcD, JumpD, BranchD, ALUControlD,
      input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
      input  Rs1D, Rs2D, RdD,
      output ValidE, RegWriteE, MemWriteE, ALUSrcE, LUIE,
      output ResultSrcE, JumpE, BranchE, ALUControlE,
      output RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
      output Rs1E, Rs2E, RdE
   );

endinterface

// File: rtl/id_ex_register_pipe_reg.sv
// Generic pipeline register: async reset, enable,
// synchronous clear that overrides enable.
module pipe_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   // Next state: clear beats enable, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = d;
      end
   end

   // State flop, zeroed asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush and
// bubble gating of control for invalid decode slots.
module id_ex_register
   import id_ex_register_pkg::*;
(
   input logic               clk,
   input logic               rst,
   id_ex_register_if.slave   bus
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;
   data_t data_d;
   data_t data_q;

   // Invalid slots load as bubbles so they never write.
   always_comb begin
      ctrl_d             = ID_EX_BUBBLE.ctrl;
      if (bus.ValidD) begin
         ctrl_d.valid       = 1'b1;
         ctrl_d.reg_write   = bus.RegWriteD;
         ctrl_d.mem_write   = bus.MemWriteD;
         ctrl_d.alu_src     = bus.ALUSrcD;
         ctrl_d.lui         = bus.LUID;
         ctrl_d.result_src  = bus.ResultSrcD;
         ctrl_d.jump        = bus.JumpD;
         ctrl_d.branch      = bus.BranchD;
         ctrl_d.alu_control = bus.ALUControlD;
      end
   end

   // Data and addresses load regardless of validity.
   always_comb begin
      data_d          = ID_EX_BUBBLE.data;
      data_d.rd1      = bus.RD1D;
      data_d.rd2      = bus.RD2D;
      data_d.pc       = bus.PCD;
      data_d.pc_plus4 = bus.PCPlus4D;
      data_d.imm_ext  = bus.ImmExtD;
      data_d.rs1      = bus.Rs1D;
      data_d.rs2      = bus.Rs2D;
      data_d.rd       = bus.RdD;
   end

   pipe_reg #(
      .W ($bits(ctrl_t))
   ) u_ctrl_reg (
      .clk (clk),
      .rst (rst),
      .en  (!bus.StallE),
      .clr (bus.FlushE),
      .d   (ctrl_d),
      .q   (ctrl_q)
   );

   pipe_reg #(
      .W ($bits(data_t))
   ) u_data_reg (
      .clk (clk),
      .rst (rst),
      .en  (!bus.StallE),
      .clr (bus.FlushE),
      .d   (data_d),
      .q   (data_q)
   );

   assign bus.ValidE      = ctrl_q.valid;
   assign bus.RegWriteE   = ctrl_q.reg_write;
   assign bus.MemWriteE   = ctrl_q.mem_write;
   assign bus.ALUSrcE     = ctrl_q.alu_src;
   assign bus.LUIE        = ctrl_q.lui;
   assign bus.ResultSrcE  = ctrl_q.result_src;
   assign bus.JumpE       = ctrl_q.jump;
   assign bus.BranchE     = ctrl_q.branch;
   assign bus.ALUControlE = ctrl_q.alu_control;
   assign bus.RD1E        = data_q.rd1;
   assign bus.RD2E        = data_q.rd2;
   assign bus.PCE         = data_q.pc;
   assign bus.PCPlus4E    = data_q.pc_plus4;
   assign bus.ImmExtE     = data_q.imm_ext;
   assign bus.Rs1E        = data_q.rs1;
   assign bus.Rs2E        = data_q.rs2;
   assign bus.RdE         = data_q.rd;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Decode-to-execute pipeline register of the five-stage RISC-V core. Each clock it captures the decoded control bundle from the decode controller, together with register-file read data, extended immediate, PC values and register addresses, and presents them to the execute stage. It implements the hazard unit's stall (hold) and flush (bubble insertion) requests. It also guarantees that a bubble never writes the register file or memory, even though the decoder's default case asserts RegWriteD.

## Interface
- XLEN, 32, datapath width for RD1/RD2/PC/PCPlus4/ImmExt
- REGW, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- StallE  in  1  hold all E outputs at current value
- FlushE  in  1  load a bubble next edge
- ValidD  in  1  decode stage holds a real instruction
- RegWriteD, MemWriteD, ALUSrcD, LUID  in  1 each  decoded control
- ResultSrcD, JumpD, BranchD  in  2 each  decoded control
- ALUControlD  in  3  ALU op
- RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  XLEN each  operands / PC data
- Rs1D, Rs2D, RdD  in  REGW each  register addresses, used for forwarding
- ValidE  out  1  execute stage holds a real instruction
- RegWriteE … LUIE, ResultSrcE, JumpE, BranchE, ALUControlE  out  widths as D  registered control
- RD1E, RD2E, PCE, PCPlus4E, ImmExtE  out  XLEN  registered data
- Rs1E, Rs2E, RdE  out  REGW  registered addresses

## Operation
- Priority at each rising edge: rst (async) > FlushE > StallE > normal load.
- Normal load: every E output takes its D input.
- Stall: every E output holds.
- Flush: bubble. ValidE=0, all control outputs 0 (RegWriteE=0, MemWriteE=0, JumpE=00, BranchE=00, ResultSrcE=00, ALUControlE=000, ALUSrcE=0, LUIE=0), all data and address outputs 0.
- Gating on ValidD=0 during a normal load: the instruction is loaded as a bubble. Control outputs, RegWriteE and MemWriteE are forced to 0, and ValidE=0. Data fields still load. Rs1E, Rs2E and RdE load as given, but forwarding logic must qualify them with RegWriteE.
- Invariant: ValidE=0 implies RegWriteE=MemWriteE=0, JumpE=BranchE=00.
- No arithmetic is performed. Widths pass through unchanged.
- Bubble encoding (all-zero) is a single constant. An all-zero bundle decodes as an ADD whose result is never written.

## Timing
- Latency: exactly one cycle, D at edge n appears at E after edge n.
- Reset: all outputs go to 0 immediately on rst assertion, independent of clk, and remain 0 while rst is high. The first load occurs on the first rising edge after deassertion.
- Reset mid-stall or mid-flush: reset wins, and state is bubble afterwards.
- FlushE and StallE both high: flush wins. The hazard unit asserts this combination on a load-use stall coincident with a taken branch.
- StallE held for N cycles: outputs are constant for N edges, and the next load occurs on the first edge with StallE=0.
- FlushE held for N cycles: N consecutive bubbles.
- No combinational path from any input to any output. All outputs come directly from flops.

## Structure
- Shared package: XLEN, REGW, and the bubble constant. Control encodings are also defined there: ResultSrc 00 ALU / 01 mem / 10 PC+4 / 11 imm; Jump 00 none / 01 JAL / 10 JALR; Branch 00 none / 01 BEQ / 10 BNE; ALU 000 add, 001 sub, 010 and, 011 or, 101 slt. Decoder and this block both import the package.
- Sub-module: pipe_reg, a parametrised-width register with async active-high reset, enable (= !StallE) and synchronous clear (= FlushE, clear wins). It is instantiated once for the packed control+valid bundle and once for the packed data+address bundle. The same module is reused for IF/ID, EX/MEM and MEM/WB.

## Test plan
- Reset: assert rst mid-cycle with non-zero E outputs -> all outputs 0 before the next edge. Deassert, drive RegWriteD=1, RdD=5, RD1D=0x1234 -> RegWriteE=1, RdE=5, RD1E=0x00001234 one edge later.
- Stall: load PCD=0x40, then StallE=1 for 3 edges with PCD=0x44 -> PCE stays 0x40 for 3 edges, then 0x44 on the edge after StallE drops.
- Flush: load MemWriteD=1, BranchD=01, FlushE=1 -> next edge MemWriteE=0, BranchE=00, ValidE=0, ImmExtE=0.
- Flush+stall together with JumpD=10 -> bubble (JumpE=00, ValidE=0), not hold.
- ValidD=0 with decoder default bundle (RegWriteD=1, RdD=7) -> RegWriteE=0, ValidE=0, RdE=7.
- Back-to-back streaming of 8 distinct instructions, no stall or flush -> each appears on E exactly one edge after presentation, in order.
